// File: rtl/fpu_issue_sched_if.sv
// Handshake bundle between decode/hazard logic, the FP datapath and the FP
// register-file write port, as seen by the FP issue scheduler.
interface fpu_issue_sched_if;
  logic        issue_valid;
  logic [1:0]  issue_op;
  logic [4:0]  issue_fd;
  logic        issue_stall;
  logic        fpu_start;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_result;
  logic        ld_valid;
  logic [4:0]  ld_fd;
  logic        ld_stall;
  logic        ld_wb_valid;
  logic        wb_valid;
  logic [4:0]  wb_fd;
  logic [31:0] wb_data;
  logic        busy;

  modport master (
    output issue_valid, issue_op, issue_fd, fpu_result, ld_valid, ld_fd, ld_wb_valid,
    input  issue_stall, fpu_start, fpu_op, ld_stall, wb_valid, wb_fd, wb_data, busy
  );

  modport slave (
    input  issue_valid, issue_op, issue_fd, fpu_result, ld_valid, ld_fd, ld_wb_valid,
    output issue_stall, fpu_start, fpu_op, ld_stall, wb_valid, wb_fd, wb_data, busy
  );
endinterface

// File: rtl/fpu_issue_sched.sv
// Issue scheduler for the shared non-pipelined FP unit: one op in flight,
// latency tracking, result capture and write-port arbitration against lwc1.
module fpu_issue_sched #(
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  fpu_issue_sched_if.slave        bus
);

  localparam int MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int MAX_LAT = (MAX_AM > DIV_LAT) ? MAX_AM : DIV_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [CW-1:0] lat_m1;
  logic [4:0]    pend_fd;
  logic [31:0]   result_q;
  logic [1:0]    fpu_op_q;
  logic          accept;
  logic          wb_fire;

  always_comb begin
    lat_m1 = CW'(ADD_LAT - 1);
    case (bus.issue_op)
      2'b10:   lat_m1 = CW'(MUL_LAT - 1);
      2'b11:   lat_m1 = CW'(DIV_LAT - 1);
      default: lat_m1 = CW'(ADD_LAT - 1);
    endcase
  end

  // Flush squashes a same-cycle accept; the reset term keeps fpu_start low while held in reset.
  assign accept  = reset & (state == IDLE) & bus.issue_valid & ~flush;
  assign wb_fire = (state == DONE) & ~bus.ld_wb_valid & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      pend_fd  <= '0;
      result_q <= '0;
      fpu_op_q <= 2'b00;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.issue_valid) begin
            state    <= BUSY;
            fpu_op_q <= bus.issue_op;
            pend_fd  <= bus.issue_fd;
            count    <= lat_m1;
          end
        end
        BUSY: begin
          if (count == '0) begin
            result_q <= bus.fpu_result;
            state    <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          // A load writing back this cycle owns the port; retry next cycle.
          if (!bus.ld_wb_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fpu_start   = accept;
  assign bus.issue_stall = bus.issue_valid & (state != IDLE);
  assign bus.ld_stall    = bus.ld_valid & (state != IDLE) & (bus.ld_fd == pend_fd);
  assign bus.busy        = (state != IDLE);
  assign bus.fpu_op      = fpu_op_q;
  assign bus.wb_valid    = wb_fire;
  assign bus.wb_fd       = wb_fire ? pend_fd : 5'd0;
  assign bus.wb_data     = wb_fire ? result_q : 32'd0;

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Self-checking bench for fpu_issue_sched: behavioural model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_fpu_issue_sched;

  localparam int ADD_LAT = 2;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 10;

  logic clk;
  logic reset;
  logic flush;
  int   checks;
  int   errors;

  fpu_issue_sched_if bus ();

  fpu_issue_sched #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      2'b10:   return MUL_LAT;
      2'b11:   return DIV_LAT;
      default: return ADD_LAT;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an op is "active" from the edge after acceptance; it computes for
  // lat cycles, then sits waiting for the write port until it gets it.
  logic        m_active;
  int          m_elapsed;
  int          m_lat;
  logic [4:0]  m_fd;
  logic [1:0]  m_op;
  logic [31:0] m_result;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active  <= 1'b0;
      m_elapsed <= 0;
      m_lat     <= 0;
      m_fd      <= '0;
      m_op      <= '0;
      m_result  <= '0;
    end else if (flush) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      if (bus.issue_valid) begin
        m_active  <= 1'b1;
        m_elapsed <= 1;
        m_lat     <= lat_of(bus.issue_op);
        m_fd      <= bus.issue_fd;
        m_op      <= bus.issue_op;
      end
    end else if (m_elapsed <= m_lat) begin
      if (m_elapsed == m_lat) m_result <= bus.fpu_result;
      m_elapsed <= m_elapsed + 1;
    end else if (!bus.ld_wb_valid) begin
      m_active <= 1'b0;
    end
  end

  always @(negedge clk) begin
    logic        e_done;
    logic        e_wb;
    if (!reset) begin
      check_output("rst_busy", bus.busy, 0);
      check_output("rst_wb_valid", bus.wb_valid, 0);
      check_output("rst_fpu_start", bus.fpu_start, 0);
      check_output("rst_fpu_op", bus.fpu_op, 0);
    end else begin
      e_done = m_active && (m_elapsed > m_lat);
      e_wb   = e_done && !bus.ld_wb_valid && !flush;
      check_output("busy", bus.busy, m_active);
      check_output("fpu_start", bus.fpu_start, !m_active && bus.issue_valid && !flush);
      check_output("issue_stall", bus.issue_stall, bus.issue_valid && m_active);
      check_output("ld_stall", bus.ld_stall, bus.ld_valid && m_active && (bus.ld_fd == m_fd));
      check_output("fpu_op", bus.fpu_op, m_op);
      check_output("wb_valid", bus.wb_valid, e_wb);
      check_output("wb_fd", bus.wb_fd, e_wb ? m_fd : 5'd0);
      check_output("wb_data", bus.wb_data, e_wb ? m_result : 32'd0);
    end
  end

  task automatic clear_inputs();
    bus.issue_valid = 1'b0;
    bus.issue_op    = 2'b00;
    bus.issue_fd    = 5'd0;
    bus.ld_valid    = 1'b0;
    bus.ld_fd       = 5'd0;
    bus.ld_wb_valid = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.fpu_result = $urandom;
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] fd);
    bus.issue_valid = 1'b1;
    bus.issue_op    = op;
    bus.issue_fd    = fd;
  endtask

  task automatic apply_stimulus();
    bus.issue_valid = ($urandom_range(99, 0) < 30);
    bus.issue_op    = 2'($urandom_range(3, 0));
    bus.issue_fd    = 5'($urandom_range(31, 0));
    bus.ld_valid    = ($urandom_range(99, 0) < 40);
    bus.ld_fd       = 5'($urandom_range(3, 0));
    bus.ld_wb_valid = ($urandom_range(99, 0) < 25);
    flush           = ($urandom_range(99, 0) < 3);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] held;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.fpu_result = '0;
    clear_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_wb_data", bus.wb_data, 32'h0);
    check_output("reset_issue_stall", bus.issue_stall, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Add, fd=4: start at cycle 0, busy 1..3, writeback at 3, idle at 4.
    step(); issue(2'b00, 5'd4);
    @(negedge clk); check_output("add_start", bus.fpu_start, 1);
    step(); clear_inputs();
    @(negedge clk); check_output("add_busy_c1", bus.busy, 1);
    step(); bus.fpu_result = 32'h41800888;
    @(negedge clk); check_output("add_busy_c2", bus.busy, 1);
    step();
    @(negedge clk);
    check_output("add_wb_valid", bus.wb_valid, 1);
    check_output("add_wb_fd", bus.wb_fd, 32'd4);
    check_output("add_wb_data", bus.wb_data, 32'h41800888);
    step();
    @(negedge clk); check_output("add_idle_c4", bus.busy, 0);

    // Div, fd=7, with a second op held from cycle 1.
    step(); issue(2'b11, 5'd7);
    for (int c = 1; c <= 11; c++) begin
      step(); issue(2'b00, 5'd9);
      @(negedge clk);
      check_output("div_issue_stall", bus.issue_stall, 1);
      if (c == 11) begin
        check_output("div_wb_valid_c11", bus.wb_valid, 1);
        check_output("div_wb_fd_c11", bus.wb_fd, 32'd7);
      end
    end
    step();
    @(negedge clk); check_output("div_next_accept_c12", bus.fpu_start, 1);
    step(); clear_inputs();
    repeat (4) step();

    // Writeback conflict on a mul, fd=2.
    step(); issue(2'b10, 5'd2);
    step(); clear_inputs();
    step();
    step(); held = bus.fpu_result;
    step(); bus.ld_wb_valid = 1'b1;
    @(negedge clk); check_output("conf_wb_blocked_1", bus.wb_valid, 0);
    step();
    @(negedge clk); check_output("conf_wb_blocked_2", bus.wb_valid, 0);
    step(); bus.ld_wb_valid = 1'b0;
    @(negedge clk);
    check_output("conf_wb_valid", bus.wb_valid, 1);
    check_output("conf_wb_fd", bus.wb_fd, 32'd2);
    check_output("conf_wb_data", bus.wb_data, held);
    step();
    @(negedge clk); check_output("conf_idle", bus.busy, 0);

    // Load hazard against a mul, fd=3.
    step(); issue(2'b10, 5'd3);
    step(); clear_inputs(); bus.ld_valid = 1'b1; bus.ld_fd = 5'd3;
    @(negedge clk); check_output("ld_hazard_same", bus.ld_stall, 1);
    step(); bus.ld_fd = 5'd5;
    @(negedge clk); check_output("ld_hazard_other", bus.ld_stall, 0);
    step(); clear_inputs();
    step();
    step(); bus.ld_valid = 1'b1; bus.ld_fd = 5'd3;
    @(negedge clk);
    check_output("ld_after_idle_busy", bus.busy, 0);
    check_output("ld_after_idle", bus.ld_stall, 0);
    step(); clear_inputs();

    // Flush in BUSY cycle 2 of a div, then flush racing an issue in IDLE.
    step(); issue(2'b11, 5'd8);
    step(); clear_inputs();
    step(); flush = 1'b1;
    step(); flush = 1'b0;
    @(negedge clk); check_output("flush_idle", bus.busy, 0);
    for (int c = 0; c < 12; c++) begin
      step();
      @(negedge clk); check_output("flush_no_wb", bus.wb_valid, 0);
    end
    step(); issue(2'b00, 5'd10); flush = 1'b1;
    @(negedge clk); check_output("flush_blocks_start", bus.fpu_start, 0);
    step(); clear_inputs();
    @(negedge clk); check_output("flush_no_accept", bus.busy, 0);

    // Async reset mid-DONE, then an add completes normally.
    step(); issue(2'b00, 5'd6);
    step(); clear_inputs();
    step();
    step();
    @(negedge clk); check_output("areset_pre_wb", bus.wb_valid, 1);
    #2 reset = 1'b0;
    #1;
    check_output("areset_busy", bus.busy, 0);
    check_output("areset_wb_valid", bus.wb_valid, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    step(); issue(2'b00, 5'd1);
    step(); clear_inputs();
    step(); bus.fpu_result = 32'h3f800000;
    step();
    @(negedge clk);
    check_output("post_reset_wb_valid", bus.wb_valid, 1);
    check_output("post_reset_wb_fd", bus.wb_fd, 32'd1);
    check_output("post_reset_wb_data", bus.wb_data, 32'h3f800000);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      step();
      apply_stimulus();
    end
    step(); clear_inputs();
    repeat (15) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
